direction_deadtime_ctrl: RTL and testbench
==========================================

Name: direction_deadtime_ctrl

Overview:
Multi-channel motor direction controller with dead-time. Takes one signed-magnitude goal angular velocity word per wheel and drives a 2-bit H-bridge direction code per channel. Adds a zero deadband and a timed brake interval on every reversal or coast-to-drive start, so the bridge is never switched straight from one direction to the other. Sits between the velocity setpoint/PID stage and the PWM/H-bridge drivers; one instance serves all wheels.

Parameters:
NCH, 4, number of motor channels
W, 32, width of each velocity word; bit W-1 = sign, bits W-2:0 = magnitude
DEADBAND, 0, magnitudes <= DEADBAND are treated as zero velocity
DEAD_CYCLES, 50000, brake cycles inserted before entering a direction (1 ms at 50 MHz); must be >= 1

Ports:
DIRECTION_DEADTIME_CTRL_CLOCK_50  in  1  system clock, all logic rising-edge
DIRECTION_DEADTIME_CTRL_RESET_InHigh  in  1  synchronous reset, active-high
DIRECTION_DEADTIME_CTRL_ENABLE_In  in  1  1 = drive allowed; 0 = all channels coast
DIRECTION_DEADTIME_CTRL_W_InBus  in  NCH*W  channel k velocity in bits [k*W +: W]
DIRECTION_DEADTIME_CTRL_CONTROL_OutBus  out  2*NCH  channel k direction code in bits [2k +: 2]
DIRECTION_DEADTIME_CTRL_REVERSING_OutBus  out  NCH  bit k = 1 while channel k is in dead-time

Behaviour:
- Codes: 00 idle/coast, 01 forward, 10 reverse, 11 fast brake.
- Per-channel request, combinational: ZERO if magnitude <= DEADBAND (either sign, so -0 is ZERO); else FWD if sign = 0; else REV.
- Per-channel FSM states and outputs: IDLE (00), STOP (11), FWD (01), REV (10), DEAD (11, REVERSING = 1). Outputs are registered and decoded from the state register, so a request change at edge N appears after edge N+1 (1-cycle latency).
- Reset: all channels IDLE, CONTROL_OutBus = 0, REVERSING_OutBus = 0, counters = 0, targets = FWD. Reset mid-DEAD aborts it with no residual count.
- ENABLE = 0 has priority over all transitions: every channel goes to IDLE on the next edge and its counter clears.
- IDLE (ENABLE = 1): ZERO -> STOP; FWD/REV -> DEAD, with target = request and counter = DEAD_CYCLES-1.
- STOP: ZERO -> stay; FWD/REV -> matching direction directly, with no dead-time because the motor is already braked.
- FWD: FWD -> stay; ZERO -> STOP; REV -> DEAD, target REV, counter loaded.
- REV: mirror of FWD.
- DEAD: a ZERO request goes to STOP immediately. A non-zero request updates target to the latest request but does not reload the counter. At counter = 0 and non-ZERO request, go to target. DEAD therefore lasts exactly DEAD_CYCLES cycles when the request is held.
- Counter width: $clog2(DEAD_CYCLES+1); no wrap, it decrements only while in DEAD and counter > 0.
- Channels are fully independent; simultaneous reversals on all channels are legal.

Decomposition:
- Package direction_pkg: code constants CTRL_IDLE/CTRL_FWD/CTRL_REV/CTRL_BRAKE, request enum (REQ_ZERO/REQ_FWD/REQ_REV), state enum (IDLE/STOP/FWD/REV/DEAD).
- Sub-module direction_deadtime_ch: one channel (request decode, FSM, counter). Top level is a generate loop over NCH plus bus slicing.

Test Plan (NCH = 2, W = 32, DEADBAND = 3, DEAD_CYCLES = 4):
- Reset held with ENABLE = 1, ch0 = +100 -> CONTROL = 0000, REVERSING = 00. Release reset -> ch0 shows 11 for 4 cycles with REVERSING[0] = 1, then 01.
- Ch0 steady 01, input switches to 0x80000064 (-100) -> 11 for exactly 4 cycles, then 10; ch1 unaffected throughout.
- Ch0 = +2 and 0x80000000 in turn -> 11 on both (deadband/negative zero); then +100 -> 01 on the next edge with no DEAD.
- Mid-DEAD: after 2 dead cycles the request returns to the original sign -> DEAD runs the remaining 2 cycles, then the new target. A second case sets the request to 0 -> 11 (STOP) next cycle with REVERSING = 0.
- ENABLE dropped during DEAD and FWD on both channels -> 0000 next cycle. ENABLE raised with ch0 = 0 and ch1 = -50 -> ch0 11 (STOP), ch1 4 cycles 11 then 10.
- Synchronous reset asserted mid-DEAD -> 00 next edge. On release with a held non-zero request, a full 4-cycle DEAD occurs (counter fully restarted).

Source files
------------

// File: rtl/direction_pkg.sv
// Shared H-bridge direction codes, request classes and channel FSM states
// used by the direction/dead-time controller.
package direction_pkg;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_FWD   = 2'b01;
  localparam logic [1:0] CTRL_REV   = 2'b10;
  localparam logic [1:0] CTRL_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    REQ_ZERO,
    REQ_FWD,
    REQ_REV
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    STOP,
    FWD,
    REV,
    DEAD
  } state_t;

endpackage

// File: rtl/direction_deadtime_ch.sv
// One motor channel: classifies the signed-magnitude velocity word and walks
// the bridge through brake/dead-time so it never flips direction directly.
module direction_deadtime_ch
  import direction_pkg::*;
#(
  parameter int W           = 32,
  parameter int DEADBAND    = 0,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] velocity,
  output logic [1:0]   control,
  output logic         reversing
);

  localparam int              CW        = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0]   DEAD_LOAD = CW'(DEAD_CYCLES - 1);
  localparam logic [W-2:0]    DB        = (W-1)'(DEADBAND);

  state_t        state;
  logic [CW-1:0] count;
  req_t          req;

  // Sign is ignored inside the deadband, so -0 counts as a zero request.
  always_comb begin
    req = REQ_ZERO;
    if (velocity[W-2:0] > DB) begin
      req = velocity[W-1] ? REQ_REV : REQ_FWD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state     <= IDLE;
      count     <= '0;
      control   <= CTRL_IDLE;
      reversing <= 1'b0;
    end else begin
      case (state)
        IDLE, FWD, REV: begin
          if (req == REQ_ZERO) begin
            state     <= STOP;
            control   <= CTRL_BRAKE;
            reversing <= 1'b0;
          end else if (!((state == FWD && req == REQ_FWD) ||
                         (state == REV && req == REQ_REV))) begin
            state     <= DEAD;
            count     <= DEAD_LOAD;
            control   <= CTRL_BRAKE;
            reversing <= 1'b1;
          end
        end
        // Already braked, so a new direction can be entered without dead-time.
        STOP: begin
          if (req == REQ_FWD) begin
            state   <= FWD;
            control <= CTRL_FWD;
          end else if (req == REQ_REV) begin
            state   <= REV;
            control <= CTRL_REV;
          end
        end
        // The latest non-zero request is the target; it never reloads the count.
        DEAD: begin
          if (req == REQ_ZERO) begin
            state     <= STOP;
            count     <= '0;
            control   <= CTRL_BRAKE;
            reversing <= 1'b0;
          end else if (count == '0) begin
            state     <= (req == REQ_FWD) ? FWD : REV;
            control   <= (req == REQ_FWD) ? CTRL_FWD : CTRL_REV;
            reversing <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          control   <= CTRL_IDLE;
          reversing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/direction_deadtime_ctrl.sv
// Multi-channel direction controller: one independent dead-time channel per
// wheel, with the velocity and code buses sliced per channel.
module direction_deadtime_ctrl #(
  parameter int NCH         = 4,
  parameter int W           = 32,
  parameter int DEADBAND    = 0,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic             DIRECTION_DEADTIME_CTRL_CLOCK_50,
  input  logic             DIRECTION_DEADTIME_CTRL_RESET_InHigh,
  input  logic             DIRECTION_DEADTIME_CTRL_ENABLE_In,
  input  logic [NCH*W-1:0] DIRECTION_DEADTIME_CTRL_W_InBus,
  output logic [2*NCH-1:0] DIRECTION_DEADTIME_CTRL_CONTROL_OutBus,
  output logic [NCH-1:0]   DIRECTION_DEADTIME_CTRL_REVERSING_OutBus
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    direction_deadtime_ch #(
      .W           (W),
      .DEADBAND    (DEADBAND),
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch (
      .clk       (DIRECTION_DEADTIME_CTRL_CLOCK_50),
      .reset     (DIRECTION_DEADTIME_CTRL_RESET_InHigh),
      .enable    (DIRECTION_DEADTIME_CTRL_ENABLE_In),
      .velocity  (DIRECTION_DEADTIME_CTRL_W_InBus[k*W +: W]),
      .control   (DIRECTION_DEADTIME_CTRL_CONTROL_OutBus[2*k +: 2]),
      .reversing (DIRECTION_DEADTIME_CTRL_REVERSING_OutBus[k])
    );
  end

endmodule

// File: tb/tb_direction_deadtime_ctrl.sv
// Directed bench for a 2-channel controller (DEADBAND 3, DEAD_CYCLES 4).
// Observed value is {REVERSING[1:0], CONTROL[3:0]}.
module tb_direction_deadtime_ctrl;

  localparam int NCH = 2;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [W-1:0]     vel0;
  logic [W-1:0]     vel1;
  logic [2*NCH-1:0] control;
  logic [NCH-1:0]   reversing;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  direction_deadtime_ctrl #(
    .NCH         (NCH),
    .W           (W),
    .DEADBAND    (3),
    .DEAD_CYCLES (4)
  ) dut (
    .DIRECTION_DEADTIME_CTRL_CLOCK_50         (clk),
    .DIRECTION_DEADTIME_CTRL_RESET_InHigh     (reset),
    .DIRECTION_DEADTIME_CTRL_ENABLE_In        (enable),
    .DIRECTION_DEADTIME_CTRL_W_InBus          ({vel1, vel0}),
    .DIRECTION_DEADTIME_CTRL_CONTROL_OutBus   (control),
    .DIRECTION_DEADTIME_CTRL_REVERSING_OutBus (reversing)
  );

  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [W-1:0] v0, input logic [W-1:0] v1);
    reset  = rst;
    enable = en;
    vel0   = v0;
    vel1   = v1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] actual,
                             input logic [5:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each edge.
  task automatic stepCheck(input string tag, input int n, input logic [5:0] expected);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s[%0d]", tag, i), {reversing, control}, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 32'd100, 32'h8000_0014);
    stepCheck("reset_hold", 2, 6'b00_00_00);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'h8000_0014);
    stepCheck("startup_dead", 4, 6'b11_11_11);
    stepCheck("startup_drive", 2, 6'b00_10_01);

    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0014);
    stepCheck("reverse_dead", 4, 6'b01_10_11);
    stepCheck("reverse_drive", 1, 6'b00_10_10);

    applyStimulus(1'b0, 1'b1, 32'd2, 32'h8000_0014);
    stepCheck("deadband_pos", 1, 6'b00_10_11);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0014);
    stepCheck("neg_zero", 1, 6'b00_10_11);
    applyStimulus(1'b0, 1'b1, 32'h8000_0003, 32'h8000_0014);
    stepCheck("deadband_edge", 1, 6'b00_10_11);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'h8000_0014);
    stepCheck("stop_to_fwd", 1, 6'b00_10_01);

    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0014);
    stepCheck("mid_dead_a", 2, 6'b01_10_11);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'h8000_0014);
    stepCheck("mid_dead_b", 2, 6'b01_10_11);
    stepCheck("mid_dead_done", 1, 6'b00_10_01);

    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0014);
    stepCheck("dead_to_zero_a", 1, 6'b01_10_11);
    applyStimulus(1'b0, 1'b1, 32'd0, 32'h8000_0014);
    stepCheck("dead_to_zero_b", 1, 6'b00_10_11);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'h8000_0014);
    stepCheck("zero_to_fwd", 1, 6'b00_10_01);

    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0014);
    stepCheck("pre_disable", 1, 6'b01_10_11);
    applyStimulus(1'b0, 1'b0, 32'h8000_0064, 32'h8000_0014);
    stepCheck("disabled", 2, 6'b00_00_00);

    applyStimulus(1'b0, 1'b1, 32'd0, 32'h8000_0032);
    stepCheck("reenable_dead", 4, 6'b10_11_11);
    stepCheck("reenable_drive", 1, 6'b00_10_11);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'h8000_0032);
    stepCheck("prep_fwd", 1, 6'b00_10_01);
    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0032);
    stepCheck("pre_reset_dead", 2, 6'b01_10_11);
    applyStimulus(1'b1, 1'b1, 32'h8000_0064, 32'h8000_0032);
    stepCheck("reset_mid_dead", 2, 6'b00_00_00);
    applyStimulus(1'b0, 1'b1, 32'h8000_0064, 32'h8000_0032);
    stepCheck("post_reset_dead", 4, 6'b11_11_11);
    stepCheck("post_reset_drive", 1, 6'b00_10_10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
